sine_cmd_decoder: RTL and testbench
===================================

Name: sine_cmd_decoder

Overview:
- Parses the UART receive byte stream into configuration for the PWM sine generator: phase tuning word, amplitude scale and output enable.
- Sits between the UART RX/TX byte engines and the sine/PWM datapath; the sine/PWM datapath consumes its register outputs directly.
- Sends a response byte stream (ACK/NAK/status) back through the UART TX byte engine.

Parameters:
- FREQ_DEFAULT, 16'h0100, reset value of freq_word.
- AMP_DEFAULT, 8'hFF, reset value of amplitude.
- TIMEOUT_CYC, 1_000_000, maximum clk cycles allowed between bytes of one frame (counter width = $clog2(TIMEOUT_CYC+1)).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received byte from UART RX
- rx_valid  input  1  one-cycle strobe; rx_data valid; no backpressure
- tx_data  output  8  response byte to UART TX
- tx_valid  output  1  response byte valid; held until accepted
- tx_ready  input  1  UART TX can accept a byte; transfer when tx_valid && tx_ready
- freq_word  output  16  phase-accumulator increment for the sine generator
- amplitude  output  8  sine amplitude scale (8'hFF = full scale)
- out_en  output  1  PWM output enable
- cfg_update  output  1  one-cycle pulse when any config register changes
- overrun  output  1  one-cycle pulse when an rx byte is dropped

Behaviour:
- Reset, asynchronous while rst_n=0:
  - freq_word=FREQ_DEFAULT, amplitude=AMP_DEFAULT, out_en=1.
  - tx_valid=0, tx_data=0, cfg_update=0, overrun=0.
  - FSM=IDLE, timeout counter=0.
- Frame format: 3 bytes: CMD, D_HI, D_LO.
- Commands:
  - 0x46 'F': freq_word={D_HI,D_LO}.
  - 0x41 'A': amplitude=D_LO; D_HI ignored.
  - 0x45 'E': out_en=D_LO[0].
  - 0x3F '?': status query; data bytes ignored.
- FSM states: IDLE, GET_HI, GET_LO, EXEC, REPLY.
  - IDLE: wait for rx_valid; latch CMD; go to GET_HI. Any CMD value is accepted at this point; validity is checked in EXEC.
  - GET_HI: on rx_valid, latch D_HI; go to GET_LO.
  - GET_LO: on rx_valid, latch D_LO; go to EXEC.
  - EXEC, exactly one cycle:
    - Write the selected register.
    - Pulse cfg_update in the same cycle, only for F/A/E.
    - Load the reply buffer, then go to REPLY.
  - Register outputs update on the clock edge that leaves EXEC, i.e. 2 cycles after the D_LO rx_valid cycle.
- Reply contents:
  - F/A/E: 1 byte, 0x4B 'K'.
  - '?': 4 bytes, in order: freq_word[15:8], freq_word[7:0], amplitude, {7'b0,out_en}. Values are those at EXEC.
  - Unknown CMD: 1 byte, 0x4E 'N'; no register change; cfg_update stays 0.
- REPLY:
  - tx_valid=1 with tx_data = current byte, held until a tx_valid&&tx_ready handshake.
  - After each handshake, advance to the next byte the following cycle.
  - After the last byte, deassert tx_valid and return to IDLE.
  - tx_ready may stay low indefinitely; the FSM waits with no timeout.
- Inter-byte timeout:
  - Counter clears on every accepted byte and counts every cycle in GET_HI/GET_LO.
  - When it reaches TIMEOUT_CYC: return to IDLE; discard the partial frame; no reply; no register change.
  - A byte arriving in the same cycle the count hits TIMEOUT_CYC is accepted, and the timeout is cancelled.
- Overrun: rx_valid during EXEC or REPLY drops the byte and pulses overrun for one cycle. The frame being replied to is unaffected.
- Register writes are atomic: freq_word updates both bytes in one edge; it never shows a half-written value.
- Reset asserted mid-frame or mid-reply: immediate return to reset values; the pending reply is abandoned.

Test Plan:
- Reset, then bytes 0x46,0x12,0x34 -> freq_word=16'h1234 two cycles after the third rx_valid; cfg_update pulses once; one TX byte 0x4B.
- Bytes 0x41,0x99,0x80 then 0x45,0x00,0x00 -> amplitude=8'h80, out_en=0; two 0x4B replies; freq_word stays FREQ_DEFAULT.
- Bytes 0x3F,0x00,0x00 with tx_ready toggling 1,0,0,1,... -> TX sequence 0x01,0x00,0xFF,0x01 with each byte held stable while tx_ready=0; no cfg_update.
- Bytes 0x5A,0x01,0x02 -> single 0x4E reply; all config outputs unchanged; cfg_update never asserts.
- TIMEOUT_CYC=100; send 0x46,0xAB, wait 100 cycles, then 0x41,0x00,0x10 -> freq_word unchanged, amplitude=8'h10, one 0x4B only.
- Hold tx_ready=0 during a 'K' reply, inject rx_valid -> overrun pulses; byte dropped; reply sent once tx_ready=1; rst_n low mid-reply clears tx_valid immediately.

Source files
------------

// File: rtl/sine_cmd_decoder.sv
// UART command decoder for the PWM sine generator: parses 3-byte CMD/D_HI/D_LO
// frames into freq/amplitude/enable registers and streams ACK/NAK/status replies.
module sine_cmd_decoder #(
  parameter logic [15:0] FREQ_DEFAULT = 16'h0100,
  parameter logic [7:0]  AMP_DEFAULT  = 8'hFF,
  parameter int          TIMEOUT_CYC  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] freq_word,
  output logic [7:0]  amplitude,
  output logic        out_en,
  output logic        cfg_update,
  output logic        overrun
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYC);

  localparam logic [7:0] C_FREQ  = 8'h46;
  localparam logic [7:0] C_AMP   = 8'h41;
  localparam logic [7:0] C_EN    = 8'h45;
  localparam logic [7:0] C_QUERY = 8'h3F;
  localparam logic [7:0] R_ACK   = 8'h4B;
  localparam logic [7:0] R_NAK   = 8'h4E;

  typedef enum logic [2:0] {S_IDLE, S_GET_HI, S_GET_LO, S_EXEC, S_REPLY} state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_cmd, r_dhi, r_dlo;
  logic [15:0]     r_freq;
  logic [7:0]      r_amp;
  logic            r_en;
  logic [CW-1:0]   r_cnt;
  logic [3:0][7:0] r_buf;
  logic [1:0]      r_idx, r_last;
  logic            w_in_get, w_timeout, w_cmd_wr, w_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_get   = (r_state == S_GET_HI) || (r_state == S_GET_LO);
    w_timeout  = w_in_get && !rx_valid && (r_cnt == TO_MAX);
    w_cmd_wr   = (r_cmd == C_FREQ) || (r_cmd == C_AMP) || (r_cmd == C_EN);
    w_hs       = (r_state == S_REPLY) && tx_ready;
    tx_valid   = (r_state == S_REPLY);
    tx_data    = (r_state == S_REPLY) ? r_buf[r_idx] : 8'h00;
    cfg_update = (r_state == S_EXEC) && w_cmd_wr;
    overrun    = rx_valid && ((r_state == S_EXEC) || (r_state == S_REPLY));
    case (r_state)
      S_IDLE:   if (rx_valid) w_next = S_GET_HI;
      S_GET_HI: if (rx_valid) w_next = S_GET_LO;
                else if (w_timeout) w_next = S_IDLE;
      S_GET_LO: if (rx_valid) w_next = S_EXEC;
                else if (w_timeout) w_next = S_IDLE;
      S_EXEC:   w_next = S_REPLY;
      S_REPLY:  if (w_hs && (r_idx == r_last)) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // A byte landing in the same cycle the count saturates wins over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_cnt <= '0;
    else if (w_in_get && !rx_valid && !w_timeout)   r_cnt <= r_cnt + 1'b1;
    else                                            r_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
      r_dhi <= '0;
      r_dlo <= '0;
    end else if (rx_valid) begin
      if (r_state == S_IDLE)   r_cmd <= rx_data;
      if (r_state == S_GET_HI) r_dhi <= rx_data;
      if (r_state == S_GET_LO) r_dlo <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq <= FREQ_DEFAULT;
      r_amp  <= AMP_DEFAULT;
      r_en   <= 1'b1;
    end else if (r_state == S_EXEC) begin
      case (r_cmd)
        C_FREQ:  r_freq <= {r_dhi, r_dlo};
        C_AMP:   r_amp  <= r_dlo;
        C_EN:    r_en   <= r_dlo[0];
        default: ;
      endcase
    end
  end

  // Reply buffer is sent from index 0 upward; status snapshots pre-EXEC values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf  <= '0;
      r_idx  <= '0;
      r_last <= '0;
    end else if (r_state == S_EXEC) begin
      r_idx <= '0;
      if (w_cmd_wr) begin
        r_buf  <= {24'h0, R_ACK};
        r_last <= 2'd0;
      end else if (r_cmd == C_QUERY) begin
        r_buf  <= {{7'b0, r_en}, r_amp, r_freq[7:0], r_freq[15:8]};
        r_last <= 2'd3;
      end else begin
        r_buf  <= {24'h0, R_NAK};
        r_last <= 2'd0;
      end
    end else if (w_hs && (r_idx != r_last)) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign freq_word = r_freq;
  assign amplitude = r_amp;
  assign out_en    = r_en;
endmodule

// File: tb/tb_sine_cmd_decoder.sv
// Directed bench for sine_cmd_decoder: frames, replies, backpressure, timeout, overrun, reset.
module tb_sine_cmd_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] freq_word;
  logic [7:0]  amplitude;
  logic        out_en;
  logic        cfg_update;
  logic        overrun;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_cfg = 0, n_ovr = 0;
  logic [7:0] txq[$];

  sine_cmd_decoder #(.FREQ_DEFAULT(16'h0100), .AMP_DEFAULT(8'hFF), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .freq_word(freq_word), .amplitude(amplitude), .out_en(out_en),
    .cfg_update(cfg_update), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Observe at the falling edge: a byte counts as sent if valid&&ready here.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (cfg_update) n_cfg++;
    if (overrun) n_ovr++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tx(input string tag, input int n, input logic [31:0] bytes);
    chk({tag, "_cnt"}, 16'(txq.size()), 16'(n));
    for (int i = 0; i < n; i++)
      chk({tag, "_byte"}, (txq.size() > i) ? 16'(txq[i]) : 16'hDEAD,
          16'(bytes[8*(n-1-i) +: 8]));
  endtask

  task automatic clr();
    txq.delete();
    n_cfg = 0;
    n_ovr = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    send(c); send(h); send(l);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
    chk("idle_tx_valid", 16'(tx_valid), 16'h0);
  endtask

  initial begin
    logic pat [4];
    logic pv, pr;
    logic [7:0] pd;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_freq", freq_word, 16'h0100);
    chk("rst_amp", 16'(amplitude), 16'h00FF);
    chk("rst_en", 16'(out_en), 16'h1);
    chk("rst_txv", 16'(tx_valid), 16'h0);
    chk("rst_txd", 16'(tx_data), 16'h0);
    chk("rst_cfg", 16'(cfg_update), 16'h0);
    chk("rst_ovr", 16'(overrun), 16'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 'F' write: EXEC cycle shows pulse with old value, next cycle the new word
    clr();
    send3(8'h46, 8'h12, 8'h34);
    @(negedge clk);
    chk("f_exec_cfg", 16'(cfg_update), 16'h1);
    chk("f_exec_old", freq_word, 16'h0100);
    @(negedge clk);
    chk("f_new", freq_word, 16'h1234);
    chk("f_txv", 16'(tx_valid), 16'h1);
    settle();
    chk_tx("f_tx", 1, 32'h4B);
    chk("f_ncfg", 16'(n_cfg), 16'd1);

    // 'A' then 'E' from defaults
    do_reset();
    clr();
    send3(8'h41, 8'h99, 8'h80);
    settle();
    send3(8'h45, 8'h00, 8'h00);
    settle();
    chk("ae_amp", 16'(amplitude), 16'h0080);
    chk("ae_en", 16'(out_en), 16'h0);
    chk("ae_freq", freq_word, 16'h0100);
    chk_tx("ae_tx", 2, 32'h4B4B);
    chk("ae_ncfg", 16'(n_cfg), 16'd2);

    // Status query under tx_ready backpressure
    do_reset();
    clr();
    send3(8'h3F, 8'h00, 8'h00);
    pv = 1'b0; pr = 1'b1; pd = 8'h00;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1 tx_ready = pat[k % 4];
      @(negedge clk);
      if (pv && !pr) begin
        chk("q_hold_v", 16'(tx_valid), 16'h1);
        chk("q_hold_d", 16'(tx_data), 16'(pd));
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
    tx_ready = 1'b1;
    settle();
    chk_tx("q_tx", 4, 32'h0100FF01);
    chk("q_ncfg", 16'(n_cfg), 16'd0);

    // Unknown command -> NAK, nothing changes
    clr();
    send3(8'h5A, 8'h01, 8'h02);
    settle();
    chk_tx("n_tx", 1, 32'h4E);
    chk("n_ncfg", 16'(n_cfg), 16'd0);
    chk("n_freq", freq_word, 16'h0100);
    chk("n_amp", 16'(amplitude), 16'h00FF);
    chk("n_en", 16'(out_en), 16'h1);

    // Inter-byte timeout discards the partial frame
    clr();
    send(8'h46); send(8'hAB);
    repeat (100) @(posedge clk);
    send3(8'h41, 8'h00, 8'h10);
    settle();
    chk("to_freq", freq_word, 16'h0100);
    chk("to_amp", 16'(amplitude), 16'h0010);
    chk_tx("to_tx", 1, 32'h4B);
    chk("to_ncfg", 16'(n_cfg), 16'd1);

    // Byte in the very cycle the count saturates is still accepted
    clr();
    send(8'h46); send(8'h12);
    repeat (99) @(posedge clk);
    send(8'h56);
    settle();
    chk("tb_freq", freq_word, 16'h1256);
    chk_tx("tb_tx", 1, 32'h4B);

    // Overrun while a reply is stalled
    clr();
    tx_ready = 1'b0;
    send3(8'h45, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    send(8'h46);
    @(negedge clk);
    chk("ov_n", 16'(n_ovr), 16'd1);
    chk("ov_txv", 16'(tx_valid), 16'h1);
    chk("ov_txd", 16'(tx_data), 16'h004B);
    chk("ov_en", 16'(out_en), 16'h0);
    @(posedge clk); #1 tx_ready = 1'b1;
    settle();
    chk_tx("ov_tx", 1, 32'h4B);
    send3(8'h41, 8'h00, 8'h20);
    settle();
    chk("ov_amp", 16'(amplitude), 16'h0020);
    chk("ov_freq", freq_word, 16'h1256);

    // Reset mid-reply abandons the reply at once
    clr();
    tx_ready = 1'b0;
    send3(8'h3F, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("mr_txv_pre", 16'(tx_valid), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_txv", 16'(tx_valid), 16'h0);
    chk("mr_freq", freq_word, 16'h0100);
    chk("mr_amp", 16'(amplitude), 16'h00FF);
    chk("mr_en", 16'(out_en), 16'h1);
    @(posedge clk); #1 rst_n = 1'b1;
    tx_ready = 1'b1;
    settle();
    chk("mr_txq", 16'(txq.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
